// File: rtl/tx_serial_7n1_pkg.sv
// Shared definitions for the 7N1 serial transmitter: FSM state codes and frame constants.
package tx_serial_7n1_pkg;

    typedef enum logic [1:0] {
        REPOUSO     = 2'd0,
        PREPARACAO  = 2'd1,
        TRANSMISSAO = 2'd2,
        FINAL       = 2'd3
    } estado_t;

    localparam int   DATA_BITS = 7;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // A one-cycle bit period still needs a 1-bit tick counter.
    function automatic int tick_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/tx_serial_7n1_fd.sv
// Datapath for tx_serial_7n1: character latch, frame shifter, baud tick counter and bit counter.
module tx_serial_7n1_fd
    import tx_serial_7n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 captura,
    input  logic                 carrega,
    input  logic                 conta,
    input  logic [DATA_BITS-1:0] dados_ascii,
    output logic                 saida,
    output logic                 fim_bit,
    output logic                 ultimo_bit
);

    localparam int N  = DATA_BITS + 1 + STOP_BITS;
    localparam int TW = tick_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BITS_LAST = 4'(N - 1);

    logic [DATA_BITS-1:0] dados_q, dados_d;
    logic [N-1:0]         desloc_q, desloc_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [3:0]           bits_q, bits_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dados_q  <= '0;
            desloc_q <= '1;
            tick_q   <= '0;
            bits_q   <= '0;
        end else begin
            dados_q  <= dados_d;
            desloc_q <= desloc_d;
            tick_q   <= tick_d;
            bits_q   <= bits_d;
        end
    end

    assign fim_bit    = conta && (tick_q == TICK_LAST);
    assign ultimo_bit = (bits_q == BITS_LAST);
    assign saida      = desloc_q[0];

    always_comb begin
        dados_d  = dados_q;
        desloc_d = desloc_q;
        tick_d   = tick_q;
        bits_d   = bits_q;
        if (captura) begin
            dados_d = dados_ascii;
        end
        if (carrega) begin
            desloc_d = {{STOP_BITS{STOP_BIT}}, dados_q, START_BIT};
            tick_d   = '0;
            bits_d   = '0;
        end else if (conta) begin
            if (fim_bit) begin
                desloc_d = {STOP_BIT, desloc_q[N-1:1]};
                tick_d   = '0;
                bits_d   = bits_q + 4'd1;
            end else begin
                tick_d   = tick_q + TW'(1);
            end
        end
    end

endmodule

// File: rtl/tx_serial_7n1.sv
// 7N1 asynchronous serial transmitter: control FSM plus datapath instance.
// Optional debug ports db_estado/db_tick exist only when TX_SERIAL_DEBUG_EN is defined.
//
//   state       | meaning
//   REPOUSO     | idle, line high, waiting for partida (character latched on accept)
//   PREPARACAO  | one cycle, frame loaded into shifter, counters cleared
//   TRANSMISSAO | shifter[0] on the line, one bit per CLKS_PER_BIT cycles
//   FINAL       | one cycle, pronto pulse
module tx_serial_7n1
    import tx_serial_7n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados_ascii,
    output logic       saida_serial,
    output logic       ocupado,
`ifdef TX_SERIAL_DEBUG_EN
    output logic [3:0] db_estado,
    output logic       db_tick,
`endif
    output logic       pronto
);

    estado_t estado_q, estado_d;

    logic captura, carrega, conta;
    logic saida_fd, fim_bit, ultimo_bit, fim_quadro;

    tx_serial_7n1_fd #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_fd (
        .clock       (clock),
        .reset       (reset),
        .captura     (captura),
        .carrega     (carrega),
        .conta       (conta),
        .dados_ascii (dados_ascii),
        .saida       (saida_fd),
        .fim_bit     (fim_bit),
        .ultimo_bit  (ultimo_bit)
    );

    assign fim_quadro = fim_bit && ultimo_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= REPOUSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            REPOUSO:     if (partida) estado_d = PREPARACAO;
            PREPARACAO:  estado_d = TRANSMISSAO;
            TRANSMISSAO: if (fim_quadro) estado_d = FINAL;
            FINAL:       estado_d = REPOUSO;
            default:     estado_d = REPOUSO;
        endcase
    end

    // Line is forced high outside TRANSMISSAO so an async reset idles it at once.
    always_comb begin
        captura      = (estado_q == REPOUSO) && partida;
        carrega      = (estado_q == PREPARACAO);
        conta        = (estado_q == TRANSMISSAO);
        ocupado      = (estado_q != REPOUSO);
        pronto       = (estado_q == FINAL);
        saida_serial = (estado_q == TRANSMISSAO) ? saida_fd : STOP_BIT;
    end

`ifdef TX_SERIAL_DEBUG_EN
    assign db_estado = {2'b00, estado_q};
    assign db_tick   = fim_bit;
`endif

endmodule
